// File: rtl/ni_packet_injector.sv
// Network-interface local-port transmitter: turns a host request plus payload stream into a
// Phoenix packet (header = dest, size = flit count, payload). Define NI_SEQNUM_EN to prepend a sequence flit.
module ni_packet_injector #(
  parameter int                  TAM_FLIT = 16,
  parameter logic [TAM_FLIT-1:0] ADDRESS  = 16'h0000,
  parameter logic [TAM_FLIT-1:0] MAX_LEN  = 16'hFFFF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [TAM_FLIT-1:0] req_dest,
  input  logic [TAM_FLIT-1:0] req_len,
  output logic                req_ready,
  input  logic                pl_valid,
  input  logic [TAM_FLIT-1:0] pl_data,
  output logic                pl_ready,
  output logic                tx,
  output logic [TAM_FLIT-1:0] data_out,
  input  logic                credit_i,
  output logic                busy,
  output logic                pkt_done,
  output logic                req_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    SIZE    = 3'd2,
    SEQ     = 3'd3,
    PAYLOAD = 3'd4
  } state_t;

  localparam logic [TAM_FLIT-1:0] ZERO = {TAM_FLIT{1'b0}};
  localparam logic [TAM_FLIT-1:0] ONE  = {{(TAM_FLIT-1){1'b0}}, 1'b1};
`ifdef NI_SEQNUM_EN
  // The sequence flit occupies one payload slot, so the host may use one fewer.
  localparam logic [TAM_FLIT-1:0] LEN_LIMIT = MAX_LEN - ONE;
`else
  localparam logic [TAM_FLIT-1:0] LEN_LIMIT = MAX_LEN;
`endif

  state_t              state_q, state_d;
  logic [TAM_FLIT-1:0] dest_q, dest_d;
  logic [TAM_FLIT-1:0] len_q, len_d;
  logic [TAM_FLIT-1:0] count_q, count_d;
  logic                pkt_done_q, pkt_done_d;
  logic                req_err_q, req_err_d;
`ifdef NI_SEQNUM_EN
  logic [15:0]         seq_q, seq_d;
`endif

  assign pkt_done = pkt_done_q;
  assign req_err  = req_err_q;

  // Next-state logic; tx/data_out/pl_ready flow straight from state and inputs.
  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    len_d      = len_q;
    count_d    = count_q;
    pkt_done_d = 1'b0;
    req_err_d  = 1'b0;
    req_ready  = 1'b0;
    busy       = 1'b1;
    tx         = 1'b0;
    data_out   = ZERO;
    pl_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          dest_d = req_dest;
          len_d  = req_len;
          // A self-addressed packet would route back to LOCAL; refuse it like an oversize one.
          if ((req_dest == ADDRESS) || ({1'b0, req_len} > {1'b0, LEN_LIMIT})) begin
            req_err_d = 1'b1;
          end else begin
            state_d = HEADER;
          end
        end else begin
          state_d = IDLE;
        end
      end
      HEADER: begin
        tx       = 1'b1;
        data_out = dest_q;
        if (credit_i) begin
          state_d = SIZE;
        end else begin
          state_d = HEADER;
        end
      end
      SIZE: begin
        tx = 1'b1;
`ifdef NI_SEQNUM_EN
        data_out = len_q + ONE;
`else
        data_out = len_q;
`endif
        if (credit_i) begin
          count_d = len_q;
`ifdef NI_SEQNUM_EN
          state_d = SEQ;
`else
          if (len_q == ZERO) begin
            state_d    = IDLE;
            pkt_done_d = 1'b1;
          end else begin
            state_d = PAYLOAD;
          end
`endif
        end else begin
          state_d = SIZE;
        end
      end
`ifdef NI_SEQNUM_EN
      SEQ: begin
        tx       = 1'b1;
        data_out = TAM_FLIT'(seq_q);
        if (credit_i) begin
          if (len_q == ZERO) begin
            state_d    = IDLE;
            pkt_done_d = 1'b1;
          end else begin
            state_d = PAYLOAD;
          end
        end else begin
          state_d = SEQ;
        end
      end
`endif
      PAYLOAD: begin
        tx       = pl_valid;
        pl_ready = pl_valid & credit_i;
        if (pl_valid) begin
          data_out = pl_data;
        end else begin
          data_out = ZERO;
        end
        if (pl_valid && credit_i) begin
          count_d = count_q - ONE;
          if (count_q == ONE) begin
            state_d    = IDLE;
            pkt_done_d = 1'b1;
          end else begin
            state_d = PAYLOAD;
          end
        end else begin
          count_d = count_q;
        end
      end
      default: begin
        state_d = IDLE;
        busy    = 1'b0;
      end
    endcase
  end

  // FSM state, captured request and handshake pulse registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      dest_q     <= ZERO;
      len_q      <= ZERO;
      count_q    <= ZERO;
      pkt_done_q <= 1'b0;
      req_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      len_q      <= len_d;
      count_q    <= count_d;
      pkt_done_q <= pkt_done_d;
      req_err_q  <= req_err_d;
    end
  end

`ifdef NI_SEQNUM_EN
  // Sequence number advances once per completed packet and wraps naturally.
  always_comb begin
    if (pkt_done_d) begin
      seq_d = seq_q + 16'd1;
    end else begin
      seq_d = seq_q;
    end
  end

  // Sequence counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seq_q <= 16'd0;
    end else begin
      seq_q <= seq_d;
    end
  end
`endif

endmodule
